// File: rtl/hazard_unit.sv
// Pipeline hazard control: stall/flush/bubble generation, trap drain and fence.i sequencing.
// Optional operand forwarding is enabled by defining HAZARD_FWD_EN.
module hazard_unit #(
    parameter int unsigned TRAP_DRAIN_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       ex_valid_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_is_load_i,
    input  logic       ex_branch_taken_i,
    input  logic       ex_fence_i_i,
    input  logic       mem_valid_i,
    input  logic [4:0] mem_rd_i,
    input  logic       wb_valid_i,
    input  logic [4:0] wb_rd_i,
    input  logic       imem_stall_i,
    input  logic       dmem_stall_i,
    input  logic       wb_trap_i,
    input  logic       icache_inv_done_i,
    output logic       pc_stall_o,
    output logic       if_id_stall_o,
    output logic       if_id_flush_o,
    output logic       if_id_prev_stall_o,
    output logic       id_ex_stall_o,
    output logic       id_ex_flush_o,
    output logic       id_ex_prev_stall_o,
    output logic       ex_mem_stall_o,
    output logic       ex_mem_flush_o,
    output logic       ex_mem_prev_stall_o,
    output logic       mem_wb_stall_o,
    output logic       mem_wb_flush_o,
    output logic       mem_wb_prev_stall_o,
    output logic       icache_inv_req_o,
    output logic [1:0] fwd_rs1_sel_o,
    output logic [1:0] fwd_rs2_sel_o
);

    typedef enum logic [1:0] {
        S_RUN,
        S_TRAP_DRAIN,
        S_FENCE_WAIT
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(TRAP_DRAIN_CYCLES);
    localparam state_t     TRAP_NEXT  = (TRAP_DRAIN_CYCLES == 0) ? S_RUN : S_TRAP_DRAIN;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       inv_req_q, inv_req_d;

    logic pc_stall_c;
    logic if_id_stall_c, id_ex_stall_c, ex_mem_stall_c, mem_wb_stall_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, mem_wb_flush_c;
    logic raw_stall;
    logic [1:0] fwd1_c, fwd2_c;

    function automatic logic rd_hit(input logic v, input logic [4:0] rd, input logic [4:0] rs);
        return v & (rd != 5'd0) & (rd == rs);
    endfunction

    logic ex_hit, mem_hit, wb_hit;
    assign ex_hit  = rd_hit(ex_valid_i,  ex_rd_i,  id_rs1_i) | rd_hit(ex_valid_i,  ex_rd_i,  id_rs2_i);
    assign mem_hit = rd_hit(mem_valid_i, mem_rd_i, id_rs1_i) | rd_hit(mem_valid_i, mem_rd_i, id_rs2_i);
    assign wb_hit  = rd_hit(wb_valid_i,  wb_rd_i,  id_rs1_i) | rd_hit(wb_valid_i,  wb_rd_i,  id_rs2_i);

`ifdef HAZARD_FWD_EN
    always_comb begin
        raw_stall = id_valid_i & ex_is_load_i & ex_hit;
        fwd1_c = rd_hit(mem_valid_i, mem_rd_i, id_rs1_i) ? 2'b01 :
                 rd_hit(wb_valid_i,  wb_rd_i,  id_rs1_i) ? 2'b10 : 2'b00;
        fwd2_c = rd_hit(mem_valid_i, mem_rd_i, id_rs2_i) ? 2'b01 :
                 rd_hit(wb_valid_i,  wb_rd_i,  id_rs2_i) ? 2'b10 : 2'b00;
    end
`else
    always_comb begin
        raw_stall = id_valid_i & (ex_hit | mem_hit | wb_hit);
        fwd1_c    = 2'b00;
        fwd2_c    = 2'b00;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            inv_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inv_req_q <= inv_req_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        inv_req_d      = 1'b0;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        mem_wb_stall_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        mem_wb_flush_c = 1'b0;

        if (wb_trap_i) begin
            // A trap wins in every state and (re)starts the drain.
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            mem_wb_flush_c = 1'b1;
            state_d        = TRAP_NEXT;
            cnt_d          = DRAIN_INIT;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (dmem_stall_i) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_stall_c  = 1'b1;
                        ex_mem_stall_c = 1'b1;
                    end else if (ex_valid_i && ex_fence_i_i) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        inv_req_d     = 1'b1;
                        state_d       = S_FENCE_WAIT;
                    end else if (ex_valid_i && ex_branch_taken_i) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (raw_stall) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                    end else if (imem_stall_i) begin
                        pc_stall_c = 1'b1;
                    end
                end
                S_TRAP_DRAIN: begin
                    if_id_flush_c = 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_RUN;
                    end
                end
                S_FENCE_WAIT: begin
                    pc_stall_c    = 1'b1;
                    if_id_flush_c = 1'b1;
                    if (dmem_stall_i) begin
                        id_ex_stall_c  = 1'b1;
                        ex_mem_stall_c = 1'b1;
                    end
                    if (icache_inv_done_i) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Everything is forced low while reset is held; pipeline registers reset themselves.
    assign pc_stall_o          = pc_stall_c     & ~rst_i;
    assign if_id_stall_o       = if_id_stall_c  & ~rst_i;
    assign id_ex_stall_o       = id_ex_stall_c  & ~rst_i;
    assign ex_mem_stall_o      = ex_mem_stall_c & ~rst_i;
    assign mem_wb_stall_o      = mem_wb_stall_c & ~rst_i;
    assign if_id_flush_o       = if_id_flush_c  & ~rst_i;
    assign id_ex_flush_o       = id_ex_flush_c  & ~rst_i;
    assign ex_mem_flush_o      = ex_mem_flush_c & ~rst_i;
    assign mem_wb_flush_o      = mem_wb_flush_c & ~rst_i;
    assign if_id_prev_stall_o  = imem_stall_i   & ~rst_i;
    assign id_ex_prev_stall_o  = if_id_stall_o;
    assign ex_mem_prev_stall_o = id_ex_stall_o;
    assign mem_wb_prev_stall_o = ex_mem_stall_o;
    assign icache_inv_req_o    = inv_req_q;
    assign fwd_rs1_sel_o       = rst_i ? 2'b00 : fwd1_c;
    assign fwd_rs2_sel_o       = rst_i ? 2'b00 : fwd2_c;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (TRAP_DRAIN_CYCLES = 3).
// Expected control vectors are {pc, if_id{s,f,p}, id_ex{s,f,p}, ex_mem{s,f,p}, mem_wb{s,f,p}}.
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, ex_valid, ex_is_load, ex_br, ex_fence, mem_valid, wb_valid;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       imem_stall, dmem_stall, wb_trap, inv_done;
    logic       pc_stall;
    logic       if_id_s, if_id_f, if_id_p, id_ex_s, id_ex_f, id_ex_p;
    logic       ex_mem_s, ex_mem_f, ex_mem_p, mem_wb_s, mem_wb_f, mem_wb_p;
    logic       inv_req;
    logic [1:0] fwd1, fwd2;
    logic [12:0] ctl;
    int checks = 0;
    int failures = 0;

    assign ctl = {pc_stall, if_id_s, if_id_f, if_id_p, id_ex_s, id_ex_f, id_ex_p,
                  ex_mem_s, ex_mem_f, ex_mem_p, mem_wb_s, mem_wb_f, mem_wb_p};

    always #5 clk = ~clk;

    hazard_unit #(.TRAP_DRAIN_CYCLES(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load),
        .ex_branch_taken_i(ex_br), .ex_fence_i_i(ex_fence),
        .mem_valid_i(mem_valid), .mem_rd_i(mem_rd),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .imem_stall_i(imem_stall), .dmem_stall_i(dmem_stall),
        .wb_trap_i(wb_trap), .icache_inv_done_i(inv_done),
        .pc_stall_o(pc_stall),
        .if_id_stall_o(if_id_s), .if_id_flush_o(if_id_f), .if_id_prev_stall_o(if_id_p),
        .id_ex_stall_o(id_ex_s), .id_ex_flush_o(id_ex_f), .id_ex_prev_stall_o(id_ex_p),
        .ex_mem_stall_o(ex_mem_s), .ex_mem_flush_o(ex_mem_f), .ex_mem_prev_stall_o(ex_mem_p),
        .mem_wb_stall_o(mem_wb_s), .mem_wb_flush_o(mem_wb_f), .mem_wb_prev_stall_o(mem_wb_p),
        .icache_inv_req_o(inv_req),
        .fwd_rs1_sel_o(fwd1), .fwd_rs2_sel_o(fwd2)
    );

    task automatic idle();
        id_valid = 0; ex_valid = 0; ex_is_load = 0; ex_br = 0; ex_fence = 0;
        mem_valid = 0; wb_valid = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        imem_stall = 0; dmem_stall = 0; wb_trap = 0; inv_done = 0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        imem_stall = 1'b1;
        #1;
        checks++;
        if (ctl !== 13'b0 || inv_req !== 1'b0 || fwd1 !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold ctl=%b inv=%b fwd1=%b required ctl=0 inv=0 fwd1=00", ctl, inv_req, fwd1);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (ctl !== 13'b0 || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ctl=%b inv=%b required ctl=0 inv=0", ctl, inv_req);
        end
    endtask

    task automatic test_imem();
        next_cycle();
        imem_stall = 1'b1;
        #1;
        checks++;
        if (ctl !== 13'b1_001_000_000_000) begin
            failures++;
            $display("FAIL imem_stall ctl=%b required %b", ctl, 13'b1_001_000_000_000);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd5;
        #1;
        checks++;
        if (ctl !== 13'b1_100_001_000_000) begin
            failures++;
            $display("FAIL load_use ctl=%b required %b", ctl, 13'b1_100_001_000_000);
        end
        next_cycle();
        id_valid = 1; id_rs1 = 5'd2; id_rs2 = 5'd3;
        #1;
        checks++;
        if (ctl !== 13'b0) begin
            failures++;
            $display("FAIL load_use_after ctl=%b required 0", ctl);
        end
        next_cycle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd0; id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1;
        checks++;
        if (ctl !== 13'b0) begin
            failures++;
            $display("FAIL load_x0 ctl=%b required 0", ctl);
        end
        next_cycle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; id_valid = 0; id_rs1 = 5'd5;
        #1;
        checks++;
        if (ctl !== 13'b0) begin
            failures++;
            $display("FAIL load_id_invalid ctl=%b required 0", ctl);
        end
        next_cycle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; id_valid = 1; id_rs2 = 5'd5; dmem_stall = 1;
        #1;
        checks++;
        if (ctl !== 13'b1_100_101_101_001) begin
            failures++;
            $display("FAIL load_use_dmem ctl=%b required %b", ctl, 13'b1_100_101_101_001);
        end
    endtask

    task automatic test_dmem_branch();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ex_valid = 1; ex_br = 1; dmem_stall = 1;
            #1;
            checks++;
            if (ctl !== 13'b1_100_101_101_001) begin
                failures++;
                $display("FAIL dmem_branch_hold%0d ctl=%b required %b", i, ctl, 13'b1_100_101_101_001);
            end
        end
        next_cycle();
        ex_valid = 1; ex_br = 1;
        #1;
        checks++;
        if (ctl !== 13'b0_010_010_000_000) begin
            failures++;
            $display("FAIL dmem_branch_flush ctl=%b required %b", ctl, 13'b0_010_010_000_000);
        end
    endtask

    task automatic test_trap_drain();
        next_cycle();
        wb_trap = 1;
        #1;
        checks++;
        if (ctl !== 13'b0_010_010_010_010) begin
            failures++;
            $display("FAIL trap_cycle ctl=%b required %b", ctl, 13'b0_010_010_010_010);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            dmem_stall = 1; ex_valid = 1; ex_br = 1;
            #1;
            checks++;
            if (ctl !== 13'b0_010_000_000_000) begin
                failures++;
                $display("FAIL trap_drain%0d ctl=%b required %b", i, ctl, 13'b0_010_000_000_000);
            end
        end
        next_cycle();
        #1;
        checks++;
        if (ctl !== 13'b0) begin
            failures++;
            $display("FAIL trap_back_to_run ctl=%b required 0", ctl);
        end
    endtask

    task automatic test_trap_reload();
        next_cycle();
        wb_trap = 1;
        next_cycle();
        wb_trap = 1;
        #1;
        checks++;
        if (ctl !== 13'b0_010_010_010_010) begin
            failures++;
            $display("FAIL trap_reload ctl=%b required %b", ctl, 13'b0_010_010_010_010);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            checks++;
            if (ctl !== 13'b0_010_000_000_000) begin
                failures++;
                $display("FAIL trap_reload_drain%0d ctl=%b required %b", i, ctl, 13'b0_010_000_000_000);
            end
        end
        next_cycle();
        #1;
        checks++;
        if (ctl !== 13'b0) begin
            failures++;
            $display("FAIL trap_reload_run ctl=%b required 0", ctl);
        end
    endtask

    task automatic test_fence();
        next_cycle();
        ex_valid = 1; ex_fence = 1;
        #1;
        checks++;
        if (ctl !== 13'b0_010_010_000_000 || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL fence_detect ctl=%b inv=%b required %b inv=0", ctl, inv_req, 13'b0_010_010_000_000);
        end
        next_cycle();
        #1;
        checks++;
        if (ctl !== 13'b1_010_000_000_000 || inv_req !== 1'b1) begin
            failures++;
            $display("FAIL fence_pulse ctl=%b inv=%b required %b inv=1", ctl, inv_req, 13'b1_010_000_000_000);
        end
        next_cycle();
        dmem_stall = 1;
        #1;
        checks++;
        if (ctl !== 13'b1_010_100_101_001 || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL fence_wait_dmem ctl=%b inv=%b required %b inv=0", ctl, inv_req, 13'b1_010_100_101_001);
        end
        next_cycle();
        inv_done = 1;
        #1;
        checks++;
        if (ctl !== 13'b1_010_000_000_000) begin
            failures++;
            $display("FAIL fence_done_cycle ctl=%b required %b", ctl, 13'b1_010_000_000_000);
        end
        next_cycle();
        #1;
        checks++;
        if (ctl !== 13'b0 || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL fence_release ctl=%b inv=%b required 0 inv=0", ctl, inv_req);
        end
    endtask

    task automatic test_forwarding();
        next_cycle();
        mem_valid = 1; mem_rd = 5'd7; wb_valid = 1; wb_rd = 5'd7; id_valid = 1; id_rs1 = 5'd7; id_rs2 = 5'd0;
        #1;
`ifdef HAZARD_FWD_EN
        checks++;
        if (fwd1 !== 2'b01 || fwd2 !== 2'b00 || ctl !== 13'b0) begin
            failures++;
            $display("FAIL fwd_mem_wins fwd1=%b fwd2=%b ctl=%b required fwd1=01 fwd2=00 ctl=0", fwd1, fwd2, ctl);
        end
`else
        checks++;
        if (fwd1 !== 2'b00 || ctl !== 13'b1_100_001_000_000) begin
            failures++;
            $display("FAIL raw_stall_mem fwd1=%b ctl=%b required fwd1=00 ctl=%b", fwd1, ctl, 13'b1_100_001_000_000);
        end
`endif
        next_cycle();
        mem_valid = 1; mem_rd = 5'd3; wb_valid = 1; wb_rd = 5'd9; id_valid = 1; id_rs1 = 5'd4; id_rs2 = 5'd9;
        #1;
`ifdef HAZARD_FWD_EN
        checks++;
        if (fwd2 !== 2'b10 || fwd1 !== 2'b00 || ctl !== 13'b0) begin
            failures++;
            $display("FAIL fwd_wb fwd1=%b fwd2=%b ctl=%b required fwd1=00 fwd2=10 ctl=0", fwd1, fwd2, ctl);
        end
`else
        checks++;
        if (fwd2 !== 2'b00 || ctl !== 13'b1_100_001_000_000) begin
            failures++;
            $display("FAIL raw_stall_wb fwd2=%b ctl=%b required fwd2=00 ctl=%b", fwd2, ctl, 13'b1_100_001_000_000);
        end
`endif
        next_cycle();
        wb_valid = 1; wb_rd = 5'd0; id_valid = 1; id_rs1 = 5'd0;
        #1;
        checks++;
        if (fwd1 !== 2'b00 || ctl !== 13'b0) begin
            failures++;
            $display("FAIL fwd_x0 fwd1=%b ctl=%b required fwd1=00 ctl=0", fwd1, ctl);
        end
    endtask

    task automatic test_reset_in_fence();
        next_cycle();
        ex_valid = 1; ex_fence = 1;
        next_cycle();
        imem_stall = 1;
        #1;
        checks++;
        if (pc_stall !== 1'b1 || inv_req !== 1'b1) begin
            failures++;
            $display("FAIL fence_before_reset pc=%b inv=%b required pc=1 inv=1", pc_stall, inv_req);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 13'b0 || inv_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_async ctl=%b inv=%b required ctl=0 inv=0", ctl, inv_req);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (ctl !== 13'b0 || pc_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_fence_run ctl=%b required 0", ctl);
        end
    endtask

    initial begin
        test_reset();
        test_imem();
        test_load_use();
        test_dmem_branch();
        test_trap_drain();
        test_trap_reload();
        test_fence();
        test_forwarding();
        test_reset_in_fence();
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
